pid_wr_sequencer: RTL and testbench
===================================

Name: pid_wr_sequencer

Overview:
- Initiator for the PID configuration write bus (wr_en / wr_addr / wr_chan / wr_data) that feeds pid_filter and sibling blocks.
- Takes 16-bit host pipe words through a valid/ready handshake and assembles them into write frames.
- Issues one single-cycle write per frame, or one write per channel for a broadcast frame.
- Sits between the host pipe-in endpoint and every block attached to the write bus.

Parameters:
- W_PW, 16, host pipe word width
- W_WR_ADDR, 16, write address width (must be ≤ W_PW)
- W_WR_CHAN, 16, write channel width (must be ≤ W_PW)
- W_WR_DATA, 48, write data width (must be a multiple of W_PW)
- N_CHAN, 8, number of valid channels
- BCAST_CHAN, 16'hFFFF, channel word that selects broadcast

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  reset; asynchronous, active-low
- pw_valid_in  in  1  host word valid
- pw_ready_out  out  1  sequencer can accept a word
- pw_data_in  in  W_PW  host word
- abort_in  in  1  synchronous flush of the current frame or broadcast
- wr_en  out  1  write strobe, one cycle per write
- wr_addr  out  W_WR_ADDR  write address
- wr_chan  out  W_WR_CHAN  write channel
- wr_data  out  W_WR_DATA  write data
- busy_out  out  1  frame in progress (state ≠ S_ADDR)
- err_out  out  1  one-cycle pulse: frame dropped because of an invalid channel
- wr_count_out  out  16  count of wr_en pulses issued; wraps

Behaviour:
- Reset values (asynchronous, while rst_n_in = 0):
  - state = S_ADDR
  - wr_en, wr_addr, wr_chan, wr_data, err_out, wr_count_out, busy_out all 0
  - pw_ready_out forced to 0
- Handshake:
  - A word is accepted on a rising edge where pw_valid_in && pw_ready_out.
  - pw_ready_out = (state ∈ {S_ADDR, S_CHAN, S_DATA}) && !abort_in; it is combinational from registered state.
- Frame format: word 0 = address (LSBs), word 1 = channel (LSBs), then W_WR_DATA/W_PW data words, most significant first.
- States:
  - S_ADDR: accept → latch address, go to S_CHAN.
  - S_CHAN: accept → latch channel, clear the data word counter, go to S_DATA.
  - S_DATA: accept → shift the word into the data register. After the last data word, go to S_ISSUE.
  - S_ISSUE (no accept):
    - channel < N_CHAN: at the next edge drive wr_en = 1 with latched addr/chan/data; state → S_ADDR.
    - channel == BCAST_CHAN: load bcast counter = 0; state → S_BCAST (no write this cycle).
    - otherwise: pulse err_out for one cycle, issue no write; state → S_ADDR.
  - S_BCAST: each edge drives wr_en = 1 with wr_chan = counter and increments the counter. After counter == N_CHAN−1 is issued, state → S_ADDR.
- Latency:
  - Unicast: last data word accepted at edge E → wr_en high between edges E+1 and E+2; ready returns after E+1. Minimum 6 cycles per 48-bit frame.
  - Broadcast: wr_en high for N_CHAN consecutive cycles starting at edge E+2.
- wr_en is registered and never high for two consecutive cycles except during S_BCAST.
- wr_addr / wr_chan / wr_data hold their last issued values while wr_en = 0.
- wr_count_out increments on every cycle wr_en is asserted; it wraps from 16'hFFFF to 0.
- abort_in has priority over everything else:
  - In any state, the next edge goes to S_ADDR and discards partial fields.
  - No wr_en is issued on the edge where abort_in is sampled high.
  - A word presented with abort_in high is not accepted.
  - In S_BCAST, writes already issued stand; the remaining channels are skipped.
- Reset asserted mid-frame or mid-broadcast: immediate return to reset values; no partial write is ever emitted after rst_n_in rises.
- pw_valid_in may drop between words. The FSM waits indefinitely, with no timeout.

Test Plan:
- Unicast: words 0x0003, 0x0002, 0x0000, 0x1234, 0x5678 back-to-back → exactly one wr_en pulse with addr=0x0003, chan=0x0002, data=48'h0000_1234_5678, two edges after the last accept; wr_count_out = 1.
- Broadcast: addr 0x0005, chan 0xFFFF, data 48'h0000_0000_00AA → 8 consecutive wr_en cycles, chan 0..7, identical addr/data; pw_ready_out low throughout; wr_count_out = 8.
- Invalid channel: chan 0x0009 with N_CHAN=8 → no wr_en, one-cycle err_out, and the next frame processes normally.
- Abort mid-broadcast on the 4th write cycle → chans 0..2 written, no further writes, busy_out low the next cycle; abort after two words of a unicast frame → no write, and the next 5 words form a clean frame.
- Gapped valid: 5-word frame with pw_valid_in toggling every other cycle → same single write as the unicast case; data bits unaffected by the idle cycles.
- Async reset: assert rst_n_in mid-frame between clock edges → outputs 0 immediately, pw_ready_out = 0; after release, a fresh frame yields exactly one correct write.

Source files
------------

// File: rtl/pid_wr_sequencer.sv
// pid_wr_sequencer: assembles host pipe words into write frames and drives the
// PID configuration write bus, one write per frame or one per channel on broadcast.
module pid_wr_sequencer #(
  parameter int W_PW = 16,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48,
  parameter int N_CHAN = 8,
  parameter logic [W_WR_CHAN-1:0] BCAST_CHAN = W_WR_CHAN'(16'hFFFF)
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 pw_valid_in,
  output logic                 pw_ready_out,
  input  logic [W_PW-1:0]      pw_data_in,
  input  logic                 abort_in,
  output logic                 wr_en,
  output logic [W_WR_ADDR-1:0] wr_addr,
  output logic [W_WR_CHAN-1:0] wr_chan,
  output logic [W_WR_DATA-1:0] wr_data,
  output logic                 busy_out,
  output logic                 err_out,
  output logic [15:0]          wr_count_out
);
  localparam int N_DW = W_WR_DATA / W_PW;
  localparam int DW_W = $clog2(N_DW + 1);

  typedef enum logic [2:0] {S_ADDR, S_CHAN, S_DATA, S_ISSUE, S_BCAST} state_t;

  state_t state, state_d;
  logic [W_WR_ADDR-1:0] addr_q;
  logic [W_WR_CHAN-1:0] chan_q, bcnt;
  logic [W_WR_DATA-1:0] data_q;
  logic [DW_W-1:0] dw_cnt;
  logic accept, last_dw, chan_ok, is_bcast, bcast_last, uni_wr, bc_wr, err_d;

  assign pw_ready_out = rst_n_in && !abort_in &&
                        (state == S_ADDR || state == S_CHAN || state == S_DATA);
  assign busy_out = state != S_ADDR;
  assign accept = pw_valid_in && pw_ready_out;
  assign last_dw = dw_cnt == DW_W'(N_DW - 1);
  assign chan_ok = chan_q < W_WR_CHAN'(N_CHAN);
  assign is_bcast = chan_q == BCAST_CHAN;
  assign bcast_last = bcnt == W_WR_CHAN'(N_CHAN - 1);

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= S_ADDR;
    else state <= state_d;

  always_comb begin
    state_d = state;
    uni_wr = 1'b0;
    bc_wr = 1'b0;
    err_d = 1'b0;
    if (abort_in) state_d = S_ADDR;
    else begin
      unique case (state)
        S_ADDR:  state_d = accept ? S_CHAN : S_ADDR;
        S_CHAN:  state_d = accept ? S_DATA : S_CHAN;
        S_DATA:  state_d = (accept && last_dw) ? S_ISSUE : S_DATA;
        S_ISSUE: begin
          uni_wr = chan_ok;
          err_d = !chan_ok && !is_bcast;
          state_d = (!chan_ok && is_bcast) ? S_BCAST : S_ADDR;
        end
        S_BCAST: begin
          bc_wr = 1'b1;
          state_d = bcast_last ? S_ADDR : S_BCAST;
        end
        default: state_d = S_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      addr_q <= '0;
      chan_q <= '0;
      data_q <= '0;
      dw_cnt <= '0;
      bcnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_chan <= '0;
      wr_data <= '0;
      err_out <= 1'b0;
      wr_count_out <= '0;
    end else begin
      wr_en <= uni_wr || bc_wr;
      err_out <= err_d;
      if (accept && state == S_ADDR) addr_q <= pw_data_in[W_WR_ADDR-1:0];
      if (accept && state == S_CHAN) begin
        chan_q <= pw_data_in[W_WR_CHAN-1:0];
        dw_cnt <= '0;
      end
      if (accept && state == S_DATA) begin
        data_q <= {data_q[W_WR_DATA-W_PW-1:0], pw_data_in};
        dw_cnt <= dw_cnt + 1'b1;
      end
      if (state == S_ISSUE) bcnt <= '0;
      if (bc_wr) bcnt <= bcnt + 1'b1;
      if (uni_wr || bc_wr) begin
        wr_addr <= addr_q;
        wr_chan <= bc_wr ? bcnt : chan_q;
        wr_data <= data_q;
        wr_count_out <= wr_count_out + 16'd1;
      end
    end
endmodule

// File: tb/tb_pid_wr_sequencer.sv
// tb_pid_wr_sequencer: scoreboard bench; a frame-level model predicts the write
// and error events, and a negedge monitor checks them as the DUT emits them.
module tb_pid_wr_sequencer;
  logic clk_in = 0, rst_n_in = 0, pw_valid_in = 0, abort_in = 0;
  logic [15:0] pw_data_in = '0;
  logic pw_ready_out, wr_en, busy_out, err_out;
  logic [15:0] wr_addr, wr_chan, wr_count_out;
  logic [47:0] wr_data;

  pid_wr_sequencer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .pw_valid_in(pw_valid_in),
    .pw_ready_out(pw_ready_out), .pw_data_in(pw_data_in), .abort_in(abort_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data),
    .busy_out(busy_out), .err_out(err_out), .wr_count_out(wr_count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        err;
    logic [15:0] a;
    logic [15:0] c;
    logic [47:0] d;
  } ev_t;

  ev_t sb[$];
  int checks = 0, errors = 0;
  logic [15:0] model_count = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: unicast, broadcast (possibly truncated) or dropped.
  task automatic push_frame(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d, input int nb);
    if (c < 16'd8) begin
      sb.push_back({1'b0, a, c, d});
      model_count++;
    end else if (c == 16'hFFFF) begin
      for (int i = 0; i < nb; i++) begin
        sb.push_back({1'b0, a, 16'(i), d});
        model_count++;
      end
    end else sb.push_back({1'b1, 16'h0, 16'h0, 48'h0});
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    bit done = 0;
    int t = 0;
    if (gap) begin
      pw_valid_in = 0;
      @(posedge clk_in); #1;
    end
    pw_valid_in = 1;
    pw_data_in = w;
    while (!done) begin
      @(negedge clk_in);
      if (pw_ready_out) begin
        @(posedge clk_in); #1;
        done = 1;
      end else if (++t > 100) begin
        check("accept_timeout", 0, 1);
        done = 1;
      end
    end
    pw_valid_in = 0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] c, input logic [47:0] d,
                            input bit gapped, input int nb);
    send_word(a, 0);
    send_word(c, gapped);
    send_word(d[47:32], gapped);
    send_word(d[31:16], gapped);
    send_word(d[15:0], gapped);
    push_frame(a, c, d, nb);
  endtask

  task automatic pulse_abort();
    abort_in = 1;
    @(posedge clk_in); #1;
    abort_in = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk_in); #1;
      t++;
    end
    repeat (3) @(posedge clk_in);
    #1;
    check("sb_empty", 64'(sb.size()), 0);
    check("wr_count", 64'(wr_count_out), 64'(model_count));
  endtask

  // Monitor: every write/err event must match the head of the scoreboard;
  // idle cycles must leave the bus holding the last issued values.
  initial begin
    ev_t e, last;
    last = '0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) last = '0;
      else begin
        if (wr_en) begin
          e = sb.size() ? sb.pop_front() : {1'b1, 96'h0};
          check("wr_kind", 64'(e.err), 0);
          check("wr_addr", 64'(wr_addr), 64'(e.a));
          check("wr_chan", 64'(wr_chan), 64'(e.c));
          check("wr_data", 64'(wr_data), 64'(e.d));
          last = {1'b0, wr_addr, wr_chan, wr_data};
        end else if ({wr_addr, wr_chan, wr_data} !== {last.a, last.c, last.d})
          check("bus_hold", {wr_addr, wr_data}, {last.a, last.d});
        if (err_out) begin
          e = sb.size() ? sb.pop_front() : '0;
          check("err_kind", 64'(e.err), 1);
        end
      end
    end
  end

  initial begin
    logic [15:0] a, c;
    logic [47:0] d;
    int t;
    #1;
    check("rst_ready", 64'(pw_ready_out), 0);
    check("rst_outs", {wr_en, busy_out, err_out, wr_count_out}, 0);
    #20 rst_n_in = 1;
    @(posedge clk_in); #1;

    // Unicast with latency check
    send_frame(16'h0003, 16'h0002, 48'h0000_1234_5678, 0, 8);
    @(negedge clk_in);
    check("lat_e1", 64'(wr_en), 0);
    @(negedge clk_in);
    check("lat_e2", 64'(wr_en), 1);
    drain();
    check("uni_count", 64'(wr_count_out), 1);

    // Broadcast: ready low through issue and all broadcast writes
    send_frame(16'h0005, 16'hFFFF, 48'h0000_0000_00AA, 0, 8);
    t = 0;
    repeat (9) begin
      @(negedge clk_in);
      if (pw_ready_out) t++;
    end
    check("bcast_ready_low", 64'(t), 0);
    drain();
    check("bcast_count", 64'(wr_count_out), 9);

    // Invalid channel, then a normal frame
    send_frame(16'h0011, 16'h0009, 48'h1111_2222_3333, 0, 8);
    send_frame(16'h0012, 16'h0007, 48'hAAAA_BBBB_CCCC, 0, 8);
    drain();

    // Abort on the 4th broadcast write cycle
    send_frame(16'h0021, 16'hFFFF, 48'hDEAD_BEEF_0001, 0, 3);
    t = 0;
    while (wr_count_out != model_count && t < 50) begin
      @(posedge clk_in); #1;
      t++;
    end
    check("bcast_wait", 64'(wr_count_out), 64'(model_count));
    pulse_abort();
    check("abort_busy", 64'(busy_out), 0);
    drain();

    // Abort after two words; a word offered with abort high is refused
    send_word(16'h0031, 0);
    send_word(16'h0001, 0);
    pw_valid_in = 1;
    pw_data_in = 16'h5555;
    abort_in = 1;
    @(negedge clk_in);
    check("abort_ready", 64'(pw_ready_out), 0);
    @(posedge clk_in); #1;
    abort_in = 0;
    pw_valid_in = 0;
    check("abort_uni_busy", 64'(busy_out), 0);
    send_frame(16'h0032, 16'h0004, 48'h0102_0304_0506, 0, 8);
    drain();

    // Gapped valid
    send_frame(16'h0003, 16'h0002, 48'h0000_1234_5678, 1, 8);
    drain();

    // Async reset mid-frame between edges
    send_word(16'h0041, 0);
    send_word(16'h0003, 0);
    pw_valid_in = 1;
    #2 rst_n_in = 0;
    #1;
    check("arst_ready", 64'(pw_ready_out), 0);
    check("arst_outs", {wr_en, busy_out, err_out, wr_count_out}, 0);
    check("arst_bus", {wr_addr, wr_chan, wr_data}, 0);
    model_count = '0;
    pw_valid_in = 0;
    repeat (2) @(negedge clk_in);
    rst_n_in = 1;
    @(posedge clk_in); #1;
    send_frame(16'h0042, 16'h0006, 48'hCAFE_F00D_0042, 0, 8);
    drain();

    // Randomized frames with gaps and occasional mid-frame aborts
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom);
      d = {16'($urandom), 32'($urandom)};
      case ($urandom_range(0, 3))
        0, 1: c = 16'($urandom_range(0, 7));
        2: c = 16'hFFFF;
        default: c = 16'($urandom_range(8, 16'hFFFE));
      endcase
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) send_word(16'($urandom), 1'($urandom));
        pulse_abort();
      end else send_frame(a, c, d, 1'($urandom), 8);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
